ball_ctrl: RTL and testbench

- Ball motion controller for pong. It is the producer of the `{en, vector}` interface that pos_ball consumes, and the consumer of pos_ball's `pos` output.
- Holds the ball direction, paces movement with a tick divider, and bounces the ball off the top and bottom walls and off the paddles.
- Detects misses, keeps scores and sequences serve, play, score and game-over.

---
 rtl/ball_ctrl_if.sv | 11 +
 rtl/ball_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ball_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_ctrl_if.sv
// Ball link between ball_ctrl (master: drives en/vector) and pos_ball (slave: returns pos).
interface ball_ctrl_if #(
    parameter int unsigned BIT_OF_WIDTH = 3
);
    logic                      en;
    logic [3:0]                vector;
    logic [2*BIT_OF_WIDTH-1:0] pos;

    modport master (output en, output vector, input pos);
    modport slave  (input en, input vector, output pos);
endinterface

// File: rtl/ball_ctrl.sv
// Pong ball motion controller: paces steps, bounces off walls/paddles, scores and sequences the game.
// Optional macro BALL_CTRL_SPEEDUP_EN: each paddle hit shortens the step period (floor 3) until the next point.
module ball_ctrl #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned BIT_OF_WIDTH = 3,
    parameter int unsigned TICK_DIV     = 8,
    parameter int unsigned PADDLE_LEN   = 3,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    ball_ctrl_if.master             bus,
    input  logic [BIT_OF_WIDTH-1:0] paddle_l_y,
    input  logic [BIT_OF_WIDTH-1:0] paddle_r_y,
    output logic                    point_l,
    output logic                    point_r,
    output logic [3:0]              score_l,
    output logic [3:0]              score_r,
    output logic                    game_over
);
    localparam int unsigned BW    = BIT_OF_WIDTH;
    localparam int unsigned SPANW = BIT_OF_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam int unsigned SCW   = 4;

    localparam logic [1:0]       MOVE_HOLD = 2'b00;
    localparam logic [1:0]       MOVE_POS  = 2'b01;
    localparam logic [1:0]       MOVE_NEG  = 2'b11;
    localparam logic [BW-1:0]    EDGE_LO   = BW'(0);
    localparam logic [BW-1:0]    EDGE_HI   = BW'(WIDTH - 1);
    localparam logic [BW-1:0]    COL_L_IN  = BW'(1);
    localparam logic [BW-1:0]    COL_R_IN  = BW'(WIDTH - 2);
    localparam logic [SCW-1:0]   WIN       = SCW'(WIN_SCORE);
    localparam logic [CNT_W-1:0] LAST_INIT = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, PLAY, SCORE, OVER} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] last;
    logic [1:0]       dx, dx_nxt, dy, dy_nxt;
    logic             serve_pos, serve_pos_nxt;
    logic [SCW-1:0]   score_l_nxt, score_r_nxt;
    logic             en_nxt, game_over_nxt, point_l_nxt, point_r_nxt;
    logic [3:0]       vector_nxt;
    logic [BW-1:0]    x, y;
    logic             step;

`ifdef BALL_CTRL_SPEEDUP_EN
    localparam logic [CNT_W-1:0] LAST_FLOOR = CNT_W'(2);
    logic [CNT_W-1:0] last_nxt;
`else
    assign last = LAST_INIT;
`endif

    assign x    = bus.pos[2*BW-1:BW];
    assign y    = bus.pos[BW-1:0];
    assign step = (cnt == last);

    // Paddle covers top..top+PADDLE_LEN-1, bottom clamped to the last row.
    function automatic logic on_paddle(input logic [BW-1:0] top, input logic [BW-1:0] row);
        logic [SPANW-1:0] bottom;
        bottom = SPANW'(top) + SPANW'(PADDLE_LEN - 1);
        if (bottom > SPANW'(WIDTH - 1)) begin
            bottom = SPANW'(WIDTH - 1);
        end
        return (row >= top) && (SPANW'(row) <= bottom);
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        dx_nxt        = dx;
        dy_nxt        = dy;
        serve_pos_nxt = serve_pos;
        score_l_nxt   = score_l;
        score_r_nxt   = score_r;
        vector_nxt    = 4'b0000;
        point_l_nxt   = 1'b0;
        point_r_nxt   = 1'b0;
`ifdef BALL_CTRL_SPEEDUP_EN
        last_nxt      = last;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PLAY;
                    cnt_nxt   = '0;
                    dx_nxt    = serve_pos ? MOVE_POS : MOVE_NEG;
                    dy_nxt    = MOVE_POS;
                end
            end
            PLAY: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (step) begin
                    cnt_nxt = '0;
                    if (x == EDGE_LO) begin
                        state_nxt     = SCORE;
                        point_r_nxt   = 1'b1;
                        score_r_nxt   = score_r + SCW'(1);
                        serve_pos_nxt = 1'b1;
`ifdef BALL_CTRL_SPEEDUP_EN
                        last_nxt      = LAST_INIT;
`endif
                    end else if (x == EDGE_HI) begin
                        state_nxt     = SCORE;
                        point_l_nxt   = 1'b1;
                        score_l_nxt   = score_l + SCW'(1);
                        serve_pos_nxt = 1'b0;
`ifdef BALL_CTRL_SPEEDUP_EN
                        last_nxt      = LAST_INIT;
`endif
                    end else begin
                        // Wall and paddle reflections may both apply in one step.
                        if (y == EDGE_LO && dy == MOVE_NEG) begin
                            dy_nxt = MOVE_POS;
                        end else if (y == EDGE_HI && dy == MOVE_POS) begin
                            dy_nxt = MOVE_NEG;
                        end
                        if (x == COL_L_IN && dx == MOVE_NEG && on_paddle(paddle_l_y, y)) begin
                            dx_nxt = MOVE_POS;
`ifdef BALL_CTRL_SPEEDUP_EN
                            if (last > LAST_FLOOR) last_nxt = last - CNT_W'(1);
`endif
                        end else if (x == COL_R_IN && dx == MOVE_POS && on_paddle(paddle_r_y, y)) begin
                            dx_nxt = MOVE_NEG;
`ifdef BALL_CTRL_SPEEDUP_EN
                            if (last > LAST_FLOOR) last_nxt = last - CNT_W'(1);
`endif
                        end
                        vector_nxt = {dx_nxt, dy_nxt};
                    end
                end
            end
            SCORE: begin
                state_nxt = (score_l == WIN || score_r == WIN) ? OVER : IDLE;
            end
            OVER: begin
                if (start) begin
                    state_nxt     = IDLE;
                    score_l_nxt   = '0;
                    score_r_nxt   = '0;
                    serve_pos_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        en_nxt        = (state_nxt == PLAY);
        game_over_nxt = (state_nxt == OVER);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dx         <= MOVE_HOLD;
            dy         <= MOVE_HOLD;
            serve_pos  <= 1'b1;
            score_l    <= '0;
            score_r    <= '0;
            bus.en     <= 1'b0;
            bus.vector <= 4'b0000;
            point_l    <= 1'b0;
            point_r    <= 1'b0;
            game_over  <= 1'b0;
`ifdef BALL_CTRL_SPEEDUP_EN
            last       <= LAST_INIT;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dx         <= dx_nxt;
            dy         <= dy_nxt;
            serve_pos  <= serve_pos_nxt;
            score_l    <= score_l_nxt;
            score_r    <= score_r_nxt;
            bus.en     <= en_nxt;
            bus.vector <= vector_nxt;
            point_l    <= point_l_nxt;
            point_r    <= point_r_nxt;
            game_over  <= game_over_nxt;
`ifdef BALL_CTRL_SPEEDUP_EN
            last       <= last_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: directed step table with forced pos, hand sequences, and a random game against a reference model.
module tb_ball_ctrl;
    localparam int unsigned W    = 8;
    localparam int unsigned BW   = 3;
    localparam int unsigned TD   = 8;
    localparam int unsigned PLEN = 3;
    localparam int unsigned WIN  = 9;
    localparam int          NROWS = 19;
    localparam int          P_IDLE = 0, P_PLAY = 1, P_SCORE = 2, P_OVER = 3;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [BW-1:0] paddle_l_y, paddle_r_y;
    logic          point_l, point_r, game_over;
    logic [3:0]    score_l, score_r;
    logic [2*BW-1:0] ball_pos, force_pos;
    logic          force_on;

    int n_checks = 0;
    int n_fail   = 0;
    int n_hits   = 0;
    int n_over   = 0;

    ball_ctrl_if #(.BIT_OF_WIDTH(BW)) bus ();

    ball_ctrl #(
        .WIDTH(W), .BIT_OF_WIDTH(BW), .TICK_DIV(TD), .PADDLE_LEN(PLEN), .WIN_SCORE(WIN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .point_l(point_l), .point_r(point_r),
        .score_l(score_l), .score_r(score_r), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // pos_ball stand-in: recentre while en=0, otherwise add the signed 2-bit vector per axis.
    always_ff @(posedge clk) begin
        if (rst || !bus.en) ball_pos <= {BW'(W / 2), BW'(W / 2)};
        else ball_pos <= {ball_pos[5:3] + {bus.vector[3], bus.vector[3:2]},
                          ball_pos[2:0] + {bus.vector[1], bus.vector[1:0]}};
    end
    assign bus.pos = force_on ? force_pos : ball_pos;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model (game rules in plain integer arithmetic) ----------------
    int m_phase, m_cnt, m_period, m_dx, m_dy, m_serve, m_sl, m_sr, m_bx, m_by;
    logic       e_en, e_pl, e_pr, e_go;
    logic [3:0] e_vec;

    function automatic logic [1:0] enc(input int d);
        return (d > 0) ? 2'b01 : (d < 0) ? 2'b11 : 2'b00;
    endfunction

    function automatic bit in_paddle(input int top, input int row);
        return (row >= top) && (row <= top + int'(PLEN) - 1);
    endfunction

    task automatic model_cycle(input bit r, input bit st, input int pl, input int pr);
        bit hit;
        e_vec = 4'b0000;
        e_pl  = 1'b0;
        e_pr  = 1'b0;
        if (r) begin
            m_phase = P_IDLE; m_sl = 0; m_sr = 0; m_serve = 1; m_period = TD;
        end else begin
            case (m_phase)
                P_IDLE: if (st) begin
                    m_phase = P_PLAY; m_cnt = 0; m_dx = m_serve; m_dy = 1;
                    m_bx = W / 2; m_by = W / 2;
                end
                P_PLAY: begin
                    if (m_cnt == m_period - 1) begin
                        m_cnt = 0;
                        check("pos_at_step", 16'(bus.pos), 16'({BW'(m_bx), BW'(m_by)}));
                        if (m_bx == 0) begin
                            m_sr++; m_serve = 1; m_phase = P_SCORE; e_pr = 1'b1; m_period = TD;
                        end else if (m_bx == W - 1) begin
                            m_sl++; m_serve = -1; m_phase = P_SCORE; e_pl = 1'b1; m_period = TD;
                        end else begin
                            hit = 0;
                            if (m_by == 0 && m_dy < 0) m_dy = 1;
                            else if (m_by == W - 1 && m_dy > 0) m_dy = -1;
                            if (m_bx == 1 && m_dx < 0 && in_paddle(pl, m_by)) begin
                                m_dx = 1; hit = 1;
                            end else if (m_bx == W - 2 && m_dx > 0 && in_paddle(pr, m_by)) begin
                                m_dx = -1; hit = 1;
                            end
                            m_bx += m_dx;
                            m_by += m_dy;
                            e_vec = {enc(m_dx), enc(m_dy)};
                            if (hit) n_hits++;
`ifdef BALL_CTRL_SPEEDUP_EN
                            if (hit && m_period > 3) m_period--;
`endif
                        end
                    end else begin
                        m_cnt++;
                    end
                end
                P_SCORE: m_phase = (m_sl == WIN || m_sr == WIN) ? P_OVER : P_IDLE;
                default: if (st) begin
                    m_sl = 0; m_sr = 0; m_serve = 1; m_phase = P_IDLE;
                end
            endcase
        end
        e_en = (m_phase == P_PLAY);
        e_go = (m_phase == P_OVER);
    endtask

    // ---------------- directed single-step table ----------------
    typedef struct {
        bit         fresh;
        logic [2:0] x, y, pl, pr;
        logic [3:0] vec;
        bit         epl, epr, hit;
    } row_t;
    row_t rows[NROWS];

    initial begin
        int per;
        rst = 1'b1; start = 1'b0; force_on = 1'b0; force_pos = '0;
        paddle_l_y = '0; paddle_r_y = '0;

        rows[0]  = '{1, 3'd4, 3'd4, 3'd0, 3'd0, 4'b0101, 0, 0, 0};
        rows[1]  = '{1, 3'd4, 3'd7, 3'd0, 3'd0, 4'b0111, 0, 0, 0};
        rows[2]  = '{0, 3'd4, 3'd0, 3'd0, 3'd0, 4'b0101, 0, 0, 0};
        rows[3]  = '{1, 3'd6, 3'd3, 3'd0, 3'd2, 4'b1101, 0, 0, 1};
        rows[4]  = '{0, 3'd1, 3'd3, 3'd2, 3'd0, 4'b0101, 0, 0, 1};
        rows[5]  = '{1, 3'd6, 3'd3, 3'd0, 3'd2, 4'b1101, 0, 0, 1};
        rows[6]  = '{0, 3'd1, 3'd3, 3'd5, 3'd0, 4'b1101, 0, 0, 0};
        rows[7]  = '{0, 3'd0, 3'd4, 3'd0, 3'd0, 4'b0000, 0, 1, 0};
        rows[8]  = '{1, 3'd6, 3'd3, 3'd0, 3'd5, 4'b0101, 0, 0, 0};
        rows[9]  = '{1, 3'd6, 3'd7, 3'd0, 3'd6, 4'b1111, 0, 0, 1};
        rows[10] = '{1, 3'd6, 3'd7, 3'd0, 3'd7, 4'b1111, 0, 0, 1};
        rows[11] = '{1, 3'd6, 3'd0, 3'd0, 3'd0, 4'b1101, 0, 0, 1};
        rows[12] = '{1, 3'd7, 3'd4, 3'd0, 3'd0, 4'b0000, 1, 0, 0};
        rows[13] = '{1, 3'd1, 3'd3, 3'd2, 3'd0, 4'b0101, 0, 0, 0};
        rows[14] = '{1, 3'd6, 3'd2, 3'd0, 3'd3, 4'b0101, 0, 0, 0};
        rows[15] = '{1, 3'd6, 3'd5, 3'd0, 3'd3, 4'b1101, 0, 0, 1};
        rows[16] = '{0, 3'd1, 3'd7, 3'd6, 3'd0, 4'b0111, 0, 0, 1};
        rows[17] = '{1, 3'd6, 3'd6, 3'd0, 3'd3, 4'b0101, 0, 0, 0};
        rows[18] = '{1, 3'd5, 3'd7, 3'd0, 3'd0, 4'b0111, 0, 0, 0};

        // Reset values
        step_clk; step_clk;
        check("reset_en", 16'(bus.en), 16'h0);
        check("reset_vector", 16'(bus.vector), 16'h0);
        check("reset_points", 16'({point_l, point_r}), 16'h0);
        check("reset_scores", 16'({score_l, score_r}), 16'h0);
        check("reset_game_over", 16'(game_over), 16'h0);
        rst = 1'b0;

        // First serve with the pos_ball stand-in in the loop
        begin
            int nonzero;
            nonzero = 0;
            start = 1'b1; step_clk; start = 1'b0;
            check("serve_en", 16'(bus.en), 16'h1);
            for (int i = 1; i <= 8; i++) begin
                if (bus.vector != 4'b0000) nonzero++;
                step_clk;
            end
            check("serve_quiet_before_step", 16'(nonzero), 16'h0);
            check("serve_first_vector", 16'(bus.vector), 16'b0101);
            step_clk;
            check("serve_vector_one_cycle", 16'(bus.vector), 16'h0);
            check("serve_pos_55", 16'(bus.pos), 16'({3'd5, 3'd5}));
        end

        // Directed step table, pos forced
        force_on = 1'b1;
        per = TD;
        for (int i = 0; i < NROWS; i++) begin
            if (rows[i].fresh) begin
                rst = 1'b1; step_clk; rst = 1'b0;
                start = 1'b1; step_clk; start = 1'b0;
                per = TD;
            end
            force_pos  = {rows[i].x, rows[i].y};
            paddle_l_y = rows[i].pl;
            paddle_r_y = rows[i].pr;
            for (int k = 0; k < per - 1; k++) step_clk;
            check($sformatf("row%0d_quiet", i), 16'(bus.vector), 16'h0);
            step_clk;
            check($sformatf("row%0d_vector", i), 16'(bus.vector), 16'(rows[i].vec));
            check($sformatf("row%0d_points", i), 16'({point_l, point_r}), 16'({rows[i].epl, rows[i].epr}));
            if (rows[i].epl || rows[i].epr) begin
                check($sformatf("row%0d_score", i), 16'(rows[i].epl ? score_l : score_r), 16'h1);
                check($sformatf("row%0d_score_en", i), 16'(bus.en), 16'h0);
                step_clk;
                check($sformatf("row%0d_pulse_end", i), 16'({point_l, point_r, bus.en}), 16'h0);
            end
`ifdef BALL_CTRL_SPEEDUP_EN
            if (rows[i].hit && per > 3) per--;
`endif
        end

        // Reset in the cycle the vector is presented
        force_pos = {3'd0, 3'd4};
        rst = 1'b1; step_clk; rst = 1'b0;
        start = 1'b1; step_clk; start = 1'b0;
        repeat (TD) step_clk;
        check("midrst_score_before", 16'(score_r), 16'h1);
        step_clk;
        force_pos = {3'd4, 3'd4};
        start = 1'b1; step_clk; start = 1'b0;
        repeat (TD) step_clk;
        check("midrst_vector", 16'(bus.vector), 16'b0101);
        rst = 1'b1; step_clk; rst = 1'b0;
        check("midrst_en", 16'(bus.en), 16'h0);
        check("midrst_vector_clr", 16'(bus.vector), 16'h0);
        check("midrst_scores", 16'({score_l, score_r}), 16'h0);
        start = 1'b1; step_clk; start = 1'b0;
        check("midrst_idle_restart", 16'(bus.en), 16'h1);

        // Random games against the reference model
        force_on = 1'b0;
        rst = 1'b1; start = 1'b0;
        model_cycle(1, 0, 0, 0);
        step_clk;
        for (int c = 0; c < 8000; c++) begin
            bit r, st;
            int pl, pr;
            logic [15:0] got, exp;
            got = {bus.en, bus.vector, point_l, point_r, score_l, score_r, game_over};
            exp = {e_en, e_vec, e_pl, e_pr, 4'(m_sl), 4'(m_sr), e_go};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rand cycle %0d: got en=%0d vec=%b pl=%0d pr=%0d sl=%0d sr=%0d go=%0d, expected en=%0d vec=%b pl=%0d pr=%0d sl=%0d sr=%0d go=%0d",
                         c, bus.en, bus.vector, point_l, point_r, score_l, score_r, game_over,
                         e_en, e_vec, e_pl, e_pr, m_sl, m_sr, e_go);
            end
            if (e_go) n_over++;
            r  = ($urandom_range(0, 3999) == 0);
            st = ($urandom_range(0, 3) == 0);
            pl = int'($urandom_range(0, W - 1));
            pr = int'($urandom_range(0, W - 1));
            rst = r; start = st;
            paddle_l_y = BW'(pl);
            paddle_r_y = BW'(pr);
            model_cycle(r, st, pl, pr);
            step_clk;
        end
        rst = 1'b0; start = 1'b0;
        check("game_over_reached", 16'(n_over > 0), 16'h1);
        check("paddle_hits_seen", 16'(n_hits > 0), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
